// File: rtl/neopixel_strip_driver.sv
// WS2812-style strip driver: per-pixel RGB frame buffer, global brightness scaling,
// serialised G,R,B MSB-first onto one registered data line followed by a latch gap.
module neopixel_strip_driver #(
   parameter int NUM_PIXELS = 8,
   parameter int T0H_CYC    = 20,
   parameter int T1H_CYC    = 40,
   parameter int BIT_CYC    = 63,
   parameter int LATCH_CYC  = 3000,
   parameter int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             load,
   input  logic [IDX_W-1:0] pixel,
   input  logic [7:0]       red,
   input  logic [7:0]       green,
   input  logic [7:0]       blue,
   input  logic             go,
   input  logic [7:0]       brightness,
   output logic             neopixel_data,
   output logic             ready,
   output logic             frame_done,
   output logic             load_err
);

   // Handshake: load and go are single-cycle strobes accepted only on an edge where
   // ready is high; anything else is dropped (load also raises load_err).

   localparam int CNT_MAX = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
   localparam logic [CNT_W-1:0] T0H_L      = CNT_W'(T0H_CYC);
   localparam logic [CNT_W-1:0] T1H_L      = CNT_W'(T1H_CYC);
   localparam logic [IDX_W-1:0] PIX_LAST   = IDX_W'(NUM_PIXELS - 1);
   localparam logic [IDX_W:0]   NUM_L      = (IDX_W + 1)'(NUM_PIXELS);

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] pix_cnt, pix_n;
   logic [4:0]       bit_cnt, bit_n;
   logic [CNT_W-1:0] cyc_cnt, cyc_n, bit_high;
   logic [23:0]      shreg, shreg_n, cur_word, pix_word;
   logic [7:0]       bright_q;
   logic [23:0]      buffer [NUM_PIXELS];
   logic             data_n, done_n, accept_go, pixel_ok, load_ok, load_bad;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
   endfunction

   assign accept_go = (state == IDLE) && go;
   assign pixel_ok  = {1'b0, pixel} < NUM_L;
   assign load_ok   = load && (state == IDLE) && pixel_ok;
   assign load_bad  = load && !((state == IDLE) && pixel_ok);

   // Buffer words are {G,R,B}; a pixel's scaled word is formed in its first cycle,
   // after which the shift register carries it.
   assign pix_word = buffer[pix_cnt];
   assign cur_word = (bit_cnt == 5'd0 && cyc_cnt == '0)
                   ? {scale(pix_word[23:16], bright_q), scale(pix_word[15:8], bright_q),
                      scale(pix_word[7:0], bright_q)}
                   : shreg;
   assign bit_high = cur_word[23] ? T1H_L : T0H_L;

   always_comb begin
      state_n = state;
      pix_n   = pix_cnt;
      bit_n   = bit_cnt;
      cyc_n   = cyc_cnt;
      shreg_n = shreg;
      data_n  = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               state_n = SEND;
               pix_n   = '0;
               bit_n   = '0;
               cyc_n   = '0;
               data_n  = 1'b1;
            end
         end
         SEND: begin
            if (cyc_cnt == BIT_LAST) begin
               cyc_n   = '0;
               shreg_n = {cur_word[22:0], 1'b0};
               data_n  = 1'b1;
               if (bit_cnt == 5'd23) begin
                  bit_n = '0;
                  if (pix_cnt == PIX_LAST) begin
                     state_n = LATCH;
                     data_n  = 1'b0;
                  end else begin
                     pix_n = pix_cnt + 1'b1;
                  end
               end else begin
                  bit_n = bit_cnt + 5'd1;
               end
            end else begin
               cyc_n   = cyc_cnt + 1'b1;
               shreg_n = cur_word;
               data_n  = cyc_n < bit_high;
            end
         end
         LATCH: begin
            if (cyc_cnt == LATCH_LAST) state_n = IDLE;
            else                       cyc_n   = cyc_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      done_n = (state_n == LATCH) && (cyc_n == LATCH_LAST);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         pix_cnt       <= '0;
         bit_cnt       <= '0;
         cyc_cnt       <= '0;
         shreg         <= '0;
         bright_q      <= '0;
         neopixel_data <= 1'b0;
         ready         <= 1'b1;
         frame_done    <= 1'b0;
         load_err      <= 1'b0;
         for (int i = 0; i < NUM_PIXELS; i++) buffer[i] <= '0;
      end else begin
         state         <= state_n;
         pix_cnt       <= pix_n;
         bit_cnt       <= bit_n;
         cyc_cnt       <= cyc_n;
         shreg         <= shreg_n;
         neopixel_data <= data_n;
         ready         <= (state_n == IDLE);
         frame_done    <= done_n;
         if (accept_go) bright_q <= brightness;
         if (load_ok) buffer[pixel] <= {green, red, blue};
         // A dropped load in the same cycle as an accepted go keeps the flag set.
         if (load_bad)       load_err <= 1'b1;
         else if (accept_go) load_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neopixel_strip_driver.sv
// Directed bench for neopixel_strip_driver (3 pixels, default bit timing):
// decodes every frame off the data line and checks words, bit shapes and frame timing.
module tb_neopixel_strip_driver;

   localparam int NP        = 3;
   localparam int T0H       = 20;
   localparam int T1H       = 40;
   localparam int BITC      = 63;
   localparam int LATCH     = 3000;
   localparam int SEND_CYC  = NP * 24 * BITC;     // 4536
   localparam int FRAME_LOW = SEND_CYC + LATCH;   // 7536

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0;
   logic       go = 1'b0;
   logic [1:0] pixel = '0;
   logic [7:0] red = '0, green = '0, blue = '0, brightness = '0;
   logic       neopixel_data, ready, frame_done, load_err;

   int checks = 0;
   int errors = 0;

   logic [23:0] cap_word [NP];
   int          cap_shape_err, cap_low, cap_done, cap_done_at;
   logic        cap_ready_back;

   neopixel_strip_driver #(
      .NUM_PIXELS(NP), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .LATCH_CYC(LATCH)
   ) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .load(load), .pixel(pixel),
      .red(red), .green(green), .blue(blue), .go(go), .brightness(brightness),
      .neopixel_data(neopixel_data), .ready(ready), .frame_done(frame_done),
      .load_err(load_err)
   );

   always #10 clk = ~clk;

   initial begin
      #(90000 * 20);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: strobes go (plus any load the caller has set up) into one edge.
   task automatic pulse_go(input logic [7:0] br);
      go = 1'b1;
      brightness = br;
      @(posedge clk);
      #1;
      go = 1'b0;
      load = 1'b0;
   endtask

   // Starts just after the accepting edge; samples every cycle from t+1 until ready returns.
   task automatic capture_frame();
      int hi;
      cap_shape_err  = 0;
      cap_low        = 0;
      cap_done       = 0;
      cap_done_at    = -1;
      cap_ready_back = 1'b0;
      for (int p = 0; p < NP; p++) begin
         cap_word[p] = '0;
         for (int b = 0; b < 24; b++) begin
            hi = 0;
            for (int c = 0; c < BITC; c++) begin
               @(negedge clk);
               if (!ready) cap_low++;
               if (frame_done) begin
                  cap_done++;
                  cap_done_at = cap_low;
               end
               if (neopixel_data === 1'b1) begin
                  if (hi != c) cap_shape_err++;
                  hi++;
               end
            end
            if (hi == T1H)      cap_word[p] = {cap_word[p][22:0], 1'b1};
            else if (hi == T0H) cap_word[p] = {cap_word[p][22:0], 1'b0};
            else begin
               cap_word[p] = {cap_word[p][22:0], 1'b0};
               cap_shape_err++;
            end
         end
      end
      for (int c = 0; c < LATCH + 20; c++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            cap_ready_back = 1'b1;
            break;
         end
         cap_low++;
         if (frame_done) begin
            cap_done++;
            cap_done_at = cap_low;
         end
         if (neopixel_data !== 1'b0) cap_shape_err++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                              input logic [23:0] e2);
      check({tag, "_word0"}, cap_word[0], e0);
      check({tag, "_word1"}, cap_word[1], e1);
      check({tag, "_word2"}, cap_word[2], e2);
      check({tag, "_shape"}, cap_shape_err, 0);
      check({tag, "_ready_back"}, cap_ready_back, 1);
      check({tag, "_ready_low"}, cap_low, FRAME_LOW);
      check({tag, "_done_count"}, cap_done, 1);
      check({tag, "_done_pos"}, cap_done_at, FRAME_LOW);
   endtask

   initial begin
      logic done_seen;

      // Power-on reset values
      repeat (3) @(negedge clk);
      check("rst_data", neopixel_data, 0);
      check("rst_ready", ready, 1);
      check("rst_done", frame_done, 0);
      check("rst_load_err", load_err, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a frame, while the line is high in bit 1
      pulse_go(8'd255);
      repeat (65) @(negedge clk);
      check("mid_data_high", neopixel_data, 1);
      check("mid_ready_low", ready, 0);
      #3 reset_n = 1'b0;
      #1;
      check("abort_data", neopixel_data, 0);
      check("abort_ready", ready, 1);
      check("abort_done", frame_done, 0);
      check("abort_load_err", load_err, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      done_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         done_seen |= frame_done;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_idle_data", neopixel_data, 0);
      check("abort_idle_ready", ready, 1);

      // All-zero buffer after reset: every bit is a 0-bit
      pulse_go(8'd255);
      capture_frame();
      check_frame("zero", 24'h000000, 24'h000000, 24'h000000);

      // Basic frame: pixel0 red only, full brightness
      load = 1'b1; pixel = 2'd0; red = 8'hFF; green = 8'h00; blue = 8'h00;
      @(negedge clk);
      load = 1'b0;
      pulse_go(8'd255);
      capture_frame();
      check_frame("basic", 24'h00FF00, 24'h000000, 24'h000000);

      // Back-to-back go on the cycle ready returns, with a same-cycle load and brightness 127
      check("b2b_ready", ready, 1);
      load = 1'b1; pixel = 2'd0; red = 8'hFF; green = 8'h80; blue = 8'h01;
      pulse_go(8'd127);
      capture_frame();
      check_frame("bright", 24'h407F00, 24'h000000, 24'h000000);

      // Busy protection: load in SEND is dropped, go in LATCH ignored, brightness latched
      pulse_go(8'd255);
      fork
         capture_frame();
         begin
            brightness = 8'd0;
            repeat (100) @(negedge clk);
            load = 1'b1; pixel = 2'd0; red = 8'h00; green = 8'hFF; blue = 8'h00;
            @(negedge clk);
            load = 1'b0;
            check("busy_load_err", load_err, 1);
            repeat (SEND_CYC + 50 - 101) @(negedge clk);
            check("latch_ready_low", ready, 0);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
         end
      join
      check_frame("busy", 24'h80FF01, 24'h000000, 24'h000000);
      check("busy_err_sticky", load_err, 1);
      repeat (5) @(negedge clk);
      check("latch_go_ignored_ready", ready, 1);
      check("latch_go_ignored_data", neopixel_data, 0);

      // Same-cycle load and go; the accepted go clears load_err
      load = 1'b1; pixel = 2'd1; red = 8'h12; green = 8'h34; blue = 8'h56;
      pulse_go(8'd255);
      fork
         capture_frame();
         begin
            @(negedge clk);
            check("go_clears_err", load_err, 0);
         end
      join
      check_frame("same_cycle", 24'h80FF01, 24'h341256, 24'h000000);

      // Out-of-range pixel index is dropped and flagged
      load = 1'b1; pixel = 2'd3; red = 8'hAA; green = 8'hBB; blue = 8'hCC;
      @(negedge clk);
      load = 1'b0;
      check("oor_load_err", load_err, 1);

      // Erroring load coincident with go: flag stays set, buffer untouched
      load = 1'b1; pixel = 2'd3; red = 8'hAA; green = 8'hBB; blue = 8'hCC;
      pulse_go(8'd255);
      fork
         capture_frame();
         begin
            @(negedge clk);
            check("set_wins_err", load_err, 1);
         end
      join
      check_frame("oor", 24'h80FF01, 24'h341256, 24'h000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neopixel_strip_driver.md
# neopixel_strip_driver

Parametrised WS2812-style strip driver: holds a NUM_PIXELS-deep RGB frame buffer, accepts per-pixel writes, and on `go` serialises the whole strip onto one data line, followed by a latch gap. Successor to the single-pixel controller path behind the board-level switch/key test harness. Adds a multi-pixel buffer, global brightness scaling, configurable bit timing, and error/done status.

## Interface
Parameters:
- NUM_PIXELS, 8: pixels on the strip (≥1).
- T0H_CYC, 20: high cycles for a 0 bit (0.4 µs at 50 MHz).
- T1H_CYC, 40: high cycles for a 1 bit (0.8 µs).
- BIT_CYC, 63: total cycles per bit. Requires BIT_CYC > T1H_CYC > T0H_CYC ≥ 1.
- LATCH_CYC, 3000: low cycles after the last bit (60 µs).
- IDX_W, max(1, $clog2(NUM_PIXELS)): derived pixel-index width.

Ports:
- CLOCK_50, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- load, in, 1: write {red, green, blue} into buffer[pixel].
- pixel, in, IDX_W: write index.
- red / green / blue, in, 8 each: write data.
- go, in, 1: start a frame.
- brightness, in, 8: global scale, sampled at accepted `go`.
- neopixel_data, out, 1: serial line to the strip, registered.
- ready, out, 1: idle; `load` and `go` are accepted only while high.
- frame_done, out, 1: one-cycle pulse at the end of the latch gap.
- load_err, out, 1: sticky flag for a dropped load.

## Operation
- States:
  - IDLE: ready=1, neopixel_data=0.
  - SEND: pixel counter, bit counter (0..23), cycle counter (0..BIT_CYC-1).
  - LATCH: cycle counter (0..LATCH_CYC-1).
- IDLE -> SEND on `go`. SEND -> LATCH after the last cycle of bit 23 of pixel NUM_PIXELS-1. LATCH -> IDLE after LATCH_CYC cycles, pulsing frame_done in the last LATCH cycle.
- Wire order: pixel 0 first. Per pixel the order is G, R, B, MSB first.
- Each bit: neopixel_data is high for T0H_CYC or T1H_CYC cycles, then low for the rest of BIT_CYC.
- Scaling: out = (c × (brightness+1)) >> 8. The product is 16 bits wide; the result is truncated to 8 bits. brightness=255 passes data through unchanged; brightness=0 gives 0 for every c.
- The scaled word for each pixel is computed when that pixel starts, from the buffer and the latched brightness.
- Load in IDLE with pixel < NUM_PIXELS: buffer written at that edge.
- The following loads are dropped and set load_err=1:
  - load while ready=0;
  - load with pixel ≥ NUM_PIXELS.
- load_err clears on the next accepted `go`. If that `go` coincides with an erroring load, the set wins.
- `go` while ready=0 is ignored, with no error.
- load and go in the same IDLE cycle: the write completes first, and the frame transmits the new value.
- Reset values:
  - neopixel_data=0, ready=1, frame_done=0, load_err=0;
  - buffer all zeros, latched brightness=0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately, asynchronously. The line goes low, and no frame_done is produced.

## Timing
- `go` sampled at edge t: ready=0 and neopixel_data=1 from t+1.
- First rising edge of data is exactly 1 cycle after the accepting edge.
- Bit k of the frame starts at t+1+k·BIT_CYC.
- Frame length: NUM_PIXELS·24·BIT_CYC + LATCH_CYC cycles from t+1.
- frame_done is high in the last cycle before ready returns to 1.
- A new `go` is accepted in the same cycle ready returns high.
- Load write latency: 1 edge. A read for serialisation sees the data on the following cycle.
- No combinational path from inputs to any output.

## Test plan
- Reset: hold reset_n=0 mid-operation, then release. Required: neopixel_data=0, ready=1, load_err=0, frame_done=0. A subsequent `go` transmits all-zero bits, each 20 cycles high then 43 low.
- Basic frame, NUM_PIXELS=2, brightness=255:
  - Stimulus: load pixel0 = R 0xFF, G 0x00, B 0x00; then `go`.
  - Required: bits 0-7 are 0-bits (20 high / 43 low); bits 8-15 are 1-bits (40 high / 23 low); bits 16-47 are 0-bits.
  - ready is low for 2·24·63+3000 = 6024 cycles; frame_done pulses once in the last of them.
- Brightness: pixel0 = R 0xFF, G 0x80, B 0x01 with brightness=127. Required wire bytes: G=0x40, R=0x7F, B=0x00.
- Busy protection:
  - load pixel0 = 0x00FF00 during SEND: load_err=1.
  - `go` during LATCH: ignored.
  - Next frame still transmits the old pixel0 value.
  - load_err clears at the next accepted `go`.
- Out-of-range and same-cycle:
  - NUM_PIXELS=3, load with pixel=3: load_err=1, buffer unchanged.
  - load pixel1 = 0x123456 in the same cycle as `go`: the frame carries G 0x34, R 0x12, B 0x56 for pixel1.
- Back-to-back: `go` asserted on the cycle ready rises. Required: a new frame starts with no gap beyond LATCH_CYC, and exactly one frame_done per frame.
